// File: rtl/regfile_hilo_if.sv
// Bus bundle for regfile_hilo: GPR write-back, two read ports, HI/LO write-back and readout.
interface regfile_hilo_if;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic        re2;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        whilo;
    logic [31:0] hi_i;
    logic [31:0] lo_i;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output we, waddr, wdata, re1, re2, raddr1, raddr2, whilo, hi_i, lo_i,
        input  rdata1, rdata2, hi_o, lo_o
    );

    modport slave (
        input  we, waddr, wdata, re1, re2, raddr1, raddr2, whilo, hi_i, lo_i,
        output rdata1, rdata2, hi_o, lo_o
    );
endinterface

// File: rtl/regfile_hilo.sv
// 32x32 GPR file with two combinational read ports plus HI/LO pair.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read outputs.
module regfile_hilo (
    input  logic             clk,
    input  logic             rst,
    regfile_hilo_if.slave    bus
);
    logic [31:0] gpr_q [32];
    logic [31:0] gpr_d [32];
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic gpr_wr;
    assign gpr_wr = bus.we && (bus.waddr != 5'd0);

    // Reset wins over any write in the same cycle; GPR0 is never stored.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            gpr_d[i] = rst ? 32'h0 : gpr_q[i];
        end
        if (!rst && gpr_wr) begin
            gpr_d[bus.waddr] = bus.wdata;
        end
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (rst) begin
            hi_d = 32'h0;
            lo_d = 32'h0;
        end else if (bus.whilo) begin
            hi_d = bus.hi_i;
            lo_d = bus.lo_i;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 32; i++) begin
            gpr_q[i] <= gpr_d[i];
        end
        hi_q <= hi_d;
        lo_q <= lo_d;
    end

    always_comb begin
        bus.rdata1 = 32'h0;
        if (!rst && bus.re1 && (bus.raddr1 != 5'd0)) begin
`ifdef REGFILE_BYPASS_EN
            if (gpr_wr && (bus.raddr1 == bus.waddr)) bus.rdata1 = bus.wdata;
            else                                     bus.rdata1 = gpr_q[bus.raddr1];
`else
            bus.rdata1 = gpr_q[bus.raddr1];
`endif
        end
    end

    always_comb begin
        bus.rdata2 = 32'h0;
        if (!rst && bus.re2 && (bus.raddr2 != 5'd0)) begin
`ifdef REGFILE_BYPASS_EN
            if (gpr_wr && (bus.raddr2 == bus.waddr)) bus.rdata2 = bus.wdata;
            else                                     bus.rdata2 = gpr_q[bus.raddr2];
`else
            bus.rdata2 = gpr_q[bus.raddr2];
`endif
        end
    end

    always_comb begin
        bus.hi_o = 32'h0;
        bus.lo_o = 32'h0;
        if (!rst) begin
`ifdef REGFILE_BYPASS_EN
            bus.hi_o = bus.whilo ? bus.hi_i : hi_q;
            bus.lo_o = bus.whilo ? bus.lo_i : lo_q;
`else
            bus.hi_o = hi_q;
            bus.lo_o = lo_q;
`endif
        end
    end
endmodule

// File: tb/tb_regfile_hilo.sv
// Directed self-checking bench for regfile_hilo; expectations follow REGFILE_BYPASS_EN.
module tb_regfile_hilo;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    regfile_hilo_if bus ();

    regfile_hilo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, leaving inputs stable away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.we = 0; bus.waddr = 0; bus.wdata = 0;
        bus.re1 = 0; bus.re2 = 0; bus.raddr1 = 0; bus.raddr2 = 0;
        bus.whilo = 0; bus.hi_i = 0; bus.lo_i = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        bus.re1 = 1; bus.raddr1 = 5; bus.we = 1; bus.waddr = 5; bus.wdata = 32'hFFFF0000;
        #2;
        chk("rst_rdata1", bus.rdata1, 32'h0);
        chk("rst_hi_o", bus.hi_o, 32'h0);
        step();

        idle(); rst = 0;
        bus.re1 = 1; bus.raddr1 = 5;
        #1;
        chk("post_rst_gpr5", bus.rdata1, 32'h0);
        chk("post_rst_hi", bus.hi_o, 32'h0);
        chk("post_rst_lo", bus.lo_o, 32'h0);

        // Write GPR5; same-cycle read depends on bypass.
        bus.we = 1; bus.waddr = 5; bus.wdata = 32'hDEADBEEF;
        #1;
        chk("wr5_same_cycle", bus.rdata1, BYP ? 32'hDEADBEEF : 32'h0);
        step();
        idle(); bus.re1 = 1; bus.raddr1 = 5; bus.re2 = 0; bus.raddr2 = 5;
        #1;
        chk("rd5_port1", bus.rdata1, 32'hDEADBEEF);
        chk("rd5_port2_disabled", bus.rdata2, 32'h0);
        bus.re2 = 1;
        #1;
        chk("rd5_port2_enabled", bus.rdata2, 32'hDEADBEEF);

        // Writes to GPR0 are dropped and never bypassed.
        idle(); bus.we = 1; bus.waddr = 0; bus.wdata = 32'h12345678;
        bus.re1 = 1; bus.raddr1 = 0;
        #1;
        chk("gpr0_same_cycle", bus.rdata1, 32'h0);
        step();
        bus.we = 0;
        #1;
        chk("gpr0_next_cycle", bus.rdata1, 32'h0);

        // Both ports on the address being written.
        idle(); bus.we = 1; bus.waddr = 7; bus.wdata = 32'hA5A5A5A5;
        bus.re1 = 1; bus.re2 = 1; bus.raddr1 = 7; bus.raddr2 = 7;
        #1;
        chk("wr7_port1_same", bus.rdata1, BYP ? 32'hA5A5A5A5 : 32'h0);
        chk("wr7_port2_same", bus.rdata2, BYP ? 32'hA5A5A5A5 : 32'h0);
        step();
        bus.we = 0;
        #1;
        chk("wr7_port1_next", bus.rdata1, 32'hA5A5A5A5);
        chk("wr7_port2_next", bus.rdata2, 32'hA5A5A5A5);
        bus.raddr2 = 5;
        #1;
        chk("ports_independent", bus.rdata2, 32'hDEADBEEF);

        // HI/LO write under reset is discarded; reset also wipes the GPRs.
        idle(); rst = 1; bus.whilo = 1; bus.hi_i = 32'h11111111; bus.lo_i = 32'h22222222;
        #1;
        chk("hilo_during_rst", bus.hi_o, 32'h0);
        step();
        rst = 0; bus.whilo = 0;
        bus.re1 = 1; bus.raddr1 = 5;
        #1;
        chk("hi_after_rst_write", bus.hi_o, 32'h0);
        chk("lo_after_rst_write", bus.lo_o, 32'h0);
        chk("gpr5_cleared", bus.rdata1, 32'h0);
        bus.whilo = 1;
        #1;
        chk("hi_same_cycle", bus.hi_o, BYP ? 32'h11111111 : 32'h0);
        chk("lo_same_cycle", bus.lo_o, BYP ? 32'h22222222 : 32'h0);
        step();
        bus.whilo = 0; bus.hi_i = 32'h0BADF00D; bus.lo_i = 32'h0BADF00D;
        #1;
        chk("hi_next_cycle", bus.hi_o, 32'h11111111);
        chk("lo_next_cycle", bus.lo_o, 32'h22222222);

        // Simultaneous GPR and HI/LO writes, then a mid-stream reset with a competing write.
        idle(); bus.we = 1; bus.waddr = 3; bus.wdata = 32'hCAFEF00D;
        bus.whilo = 1; bus.hi_i = 32'h33333333; bus.lo_i = 32'h44444444;
        step();
        idle(); bus.re1 = 1; bus.raddr1 = 3;
        #1;
        chk("gpr3_written", bus.rdata1, 32'hCAFEF00D);
        chk("hi_dual_write", bus.hi_o, 32'h33333333);
        chk("lo_dual_write", bus.lo_o, 32'h44444444);
        rst = 1; bus.we = 1; bus.waddr = 3; bus.wdata = 32'hFFFFFFFF;
        bus.whilo = 1; bus.hi_i = 32'h55555555; bus.lo_i = 32'h66666666;
        #1;
        chk("rdata1_held_in_rst", bus.rdata1, 32'h0);
        chk("lo_held_in_rst", bus.lo_o, 32'h0);
        step();
        idle(); rst = 0; bus.re1 = 1; bus.raddr1 = 3;
        #1;
        chk("gpr3_after_rst", bus.rdata1, 32'h0);
        chk("hi_after_rst", bus.hi_o, 32'h0);

        // Contents hold while the enable is low, whatever the data bus shows.
        idle(); bus.we = 1; bus.waddr = 31; bus.wdata = 32'h80000001;
        step();
        bus.we = 0; bus.wdata = 32'h7FFFFFFE; bus.re2 = 1; bus.raddr2 = 31;
        step();
        #1;
        chk("gpr31_hold", bus.rdata2, 32'h80000001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
